// File: rtl/rayforge_pkg.sv
// Shared fixed-point types, sphere/ray payloads and scheduler states for the ray pipeline.
package rayforge_pkg;

  localparam int unsigned FIX_W     = 12;
  localparam int unsigned FRAC_BITS = 4;

  typedef logic signed [FIX_W-1:0] fix12_t;

  typedef struct packed {
    fix12_t cx;
    fix12_t cy;
    fix12_t cz;
    fix12_t radius;
    logic   enable;
  } sphere_t;

  typedef struct packed {
    fix12_t ox;
    fix12_t oy;
    fix12_t oz;
    fix12_t dx;
    fix12_t dy;
    fix12_t dz;
  } ray_t;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} sched_state_t;

endpackage

// File: rtl/ray_sphere_intersect.sv
// Combinational ray/sphere test: nearest positive root of |o + t*d - c| = r, t in Q(FRAC_BITS).
// Direction is assumed unit length; t saturates at the largest positive fix12 value.
module ray_sphere_intersect
  import rayforge_pkg::*;
(
  input  logic    validIn,
  input  ray_t    ray,
  input  sphere_t sphere,
  output logic    validOut,
  output logic    hit,
  output fix12_t  t
);

  localparam int unsigned AW    = 64;
  localparam int unsigned SQ_W  = 48;
  localparam int unsigned RT_W  = SQ_W / 2;
  localparam logic signed [AW-1:0] T_MAX = AW'(2047);

  logic signed [AW-1:0] lx, ly, lz, dot, tca, ll, disc, root, t0, t1, tsel;
  logic                 disc_neg;
  logic [RT_W-1:0]      sq;

  // Floor square root, one result bit per iteration.
  function automatic logic [RT_W-1:0] isqrt(input logic [SQ_W-1:0] v);
    logic [SQ_W-1:0] x, r, b;
    x = v;
    r = '0;
    b = SQ_W'(1) << (SQ_W - 2);
    for (int unsigned i = 0; i < RT_W; i++) begin
      if (x >= r + b) begin
        x = x - (r + b);
        r = (r >> 1) + b;
      end else begin
        r = r >> 1;
      end
      b = b >> 2;
    end
    return r[RT_W-1:0];
  endfunction

  always_comb begin
    lx       = AW'(sphere.cx) - AW'(ray.ox);
    ly       = AW'(sphere.cy) - AW'(ray.oy);
    lz       = AW'(sphere.cz) - AW'(ray.oz);
    dot      = lx * AW'(ray.dx) + ly * AW'(ray.dy) + lz * AW'(ray.dz);
    tca      = dot >>> FRAC_BITS;
    ll       = lx * lx + ly * ly + lz * lz;
    // Half-chord squared, in the same Q(2*FRAC_BITS) scale as ll.
    disc     = AW'(sphere.radius) * AW'(sphere.radius) - ll + tca * tca;
    disc_neg = disc < AW'(0);
    sq       = isqrt(disc[SQ_W-1:0]);
    root     = {{(AW-RT_W){1'b0}}, sq};
    t0       = tca - root;
    t1       = tca + root;
    tsel     = (t0 > AW'(0)) ? t0 : t1;
    validOut = validIn;
    hit      = validIn && !disc_neg && (tsel > AW'(0));
    t        = '0;
    if (hit) begin
      t = (tsel > T_MAX) ? fix12_t'(T_MAX[FIX_W-1:0]) : fix12_t'(tsel[FIX_W-1:0]);
    end
  end

endmodule

// File: rtl/sphere_scene_scheduler.sv
// Walks the sphere table one entry per clock through a shared intersect unit and
// returns the nearest positive hit for each accepted ray.
module sphere_scene_scheduler
  import rayforge_pkg::*;
#(
  parameter int unsigned NUM_SPHERES = 4,
  parameter int unsigned IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfgWe,
  input  logic [IDX_W-1:0] cfgIdx,
  input  fix12_t           cfgCx,
  input  fix12_t           cfgCy,
  input  fix12_t           cfgCz,
  input  fix12_t           cfgRadius,
  input  logic             cfgEnable,
  output logic             cfgBusy,
  input  logic             rayValid,
  output logic             rayReady,
  input  fix12_t           ox,
  input  fix12_t           oy,
  input  fix12_t           oz,
  input  fix12_t           dx,
  input  fix12_t           dy,
  input  fix12_t           dz,
  output logic             resultValid,
  input  logic             resultReady,
  output logic             resultHit,
  output fix12_t           resultT,
  output logic [IDX_W-1:0] resultIdx
);

  sched_state_t     state, next_state;
  sphere_t          table_q [NUM_SPHERES];
  ray_t             ray_q;
  logic [IDX_W-1:0] cnt;
  logic             best_hit;
  fix12_t           best_t;
  logic [IDX_W-1:0] best_idx;
  logic             ray_ready_q, busy_q, res_valid_q;

  logic             ray_accept, last, scanning;
  sphere_t          entry;
  logic             is_valid, is_hit, candidate, better;
  fix12_t           is_t;

  assign scanning  = (state == SCAN);
  assign last      = (32'(cnt) == NUM_SPHERES - 1);
  assign entry     = table_q[cnt];
  assign candidate = is_valid && is_hit && entry.enable;
  assign better    = !best_hit || (is_t < best_t);

  ray_sphere_intersect u_isect (
    .validIn  (scanning),
    .ray      (ray_q),
    .sphere   (entry),
    .validOut (is_valid),
    .hit      (is_hit),
    .t        (is_t)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ray_accept = 1'b0;
    case (state)
      IDLE: begin
        if (rayValid) begin
          ray_accept = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN:    if (last) next_state = DONE;
      DONE:    if (resultReady) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Table writes land on the same edge as a ray accept, so that ray sees them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SPHERES; i++) table_q[i] <= '0;
    end else if (state == IDLE && cfgWe && 32'(cfgIdx) < NUM_SPHERES) begin
      table_q[cfgIdx] <= '{cx: cfgCx, cy: cfgCy, cz: cfgCz, radius: cfgRadius, enable: cfgEnable};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ray_q       <= '0;
      cnt         <= '0;
      best_hit    <= 1'b0;
      best_t      <= '0;
      best_idx    <= '0;
      ray_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      ray_ready_q <= (next_state == IDLE);
      busy_q      <= (next_state != IDLE);
      res_valid_q <= (next_state == DONE);
      if (ray_accept) begin
        ray_q    <= '{ox, oy, oz, dx, dy, dz};
        cnt      <= '0;
        best_hit <= 1'b0;
        best_t   <= '0;
        best_idx <= '0;
      end else if (scanning) begin
        if (!last) cnt <= cnt + IDX_W'(1);
        // Strict compare keeps the lower index on equal t.
        if (candidate && better) begin
          best_hit <= 1'b1;
          best_t   <= is_t;
          best_idx <= cnt;
        end
      end
    end
  end

  assign rayReady    = ray_ready_q;
  assign cfgBusy     = busy_q;
  assign resultValid = res_valid_q;
  assign resultHit   = best_hit;
  assign resultT     = best_t;
  assign resultIdx   = best_idx;

endmodule
